// File: rtl/placement_dump_pkg.sv
// Shared constants for the placement read-back engine: geometry, memory widths,
// FSM state encoding and record flag bit positions.
package placement_pkg;

  localparam int N       = 8;
  localparam int DW      = 32;
  localparam int GRID_AW = 12;
  localparam int POS_AW  = 7;
  localparam int CW      = $clog2(N);

  localparam logic [DW-1:0] EMPTY     = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] POS_LIMIT = DW'(1) << POS_AW;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GRD_RD   = 4'd1;
  localparam logic [3:0] S_GRD_WAIT = 4'd2;
  localparam logic [3:0] S_GRD_CHK  = 4'd3;
  localparam logic [3:0] S_POS_RD   = 4'd4;
  localparam logic [3:0] S_POS_WAIT = 4'd5;
  localparam logic [3:0] S_POS_CHK  = 4'd6;
  localparam logic [3:0] S_EMIT     = 4'd7;
  localparam logic [3:0] S_ADV      = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam int FLAG_MISMATCH = 0;
  localparam int FLAG_RANGE    = 1;

endpackage

// File: rtl/placement_dump_grid_scan_counter.sv
// Row/column scan counter over the N x N grid; col wraps into a row increment,
// and last marks the final cell so the scanner knows when to stop.
module grid_scan_counter
  import placement_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  assign last = (row == CW'(N - 1)) && (col == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv && !last) begin
      if (col == CW'(N - 1)) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/placement_dump.sv
// Scans the grid RAM, cross-checks each occupied cell against pos_X/pos_Y and
// streams one (node, x, y, flags) record per occupied cell over valid/ready.
module placement_dump
  import placement_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               reGrid,
  output logic [GRID_AW-1:0] addrGrid,
  input  logic [DW-1:0]      doutGrid,
  output logic               rePX,
  output logic               rePY,
  output logic [POS_AW-1:0]  addrPos,
  input  logic [DW-1:0]      doutPX,
  input  logic [DW-1:0]      doutPY,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [DW-1:0]      rec_node,
  output logic [DW-1:0]      rec_x,
  output logic [DW-1:0]      rec_y,
  output logic [1:0]         rec_flags,
  output logic [15:0]        cell_count,
  output logic [15:0]        err_count
);

  logic [3:0]         state;
  logic [CW-1:0]      row;
  logic [CW-1:0]      col;
  logic               last;
  logic [GRID_AW-1:0] grid_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  grid_scan_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_IDLE && start),
    .adv   (state == S_ADV),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  assign grid_addr = GRID_AW'(row) * GRID_AW'(N) + GRID_AW'(col);

  // Strobes are registered and default low, so each read pulses for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      reGrid     <= 1'b0;
      addrGrid   <= '0;
      rePX       <= 1'b0;
      rePY       <= 1'b0;
      addrPos    <= '0;
      rec_valid  <= 1'b0;
      rec_node   <= '0;
      rec_x      <= '0;
      rec_y      <= '0;
      rec_flags  <= '0;
      cell_count <= '0;
      err_count  <= '0;
    end else begin
      done   <= 1'b0;
      reGrid <= 1'b0;
      rePX   <= 1'b0;
      rePY   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cell_count <= '0;
            err_count  <= '0;
            busy       <= 1'b1;
            state      <= S_GRD_RD;
          end
        end
        S_GRD_RD: begin
          reGrid   <= 1'b1;
          addrGrid <= grid_addr;
          state    <= S_GRD_WAIT;
        end
        S_GRD_WAIT: state <= S_GRD_CHK;
        S_GRD_CHK: begin
          if (doutGrid == EMPTY) begin
            state <= S_ADV;
          end else begin
            rec_node  <= doutGrid;
            rec_x     <= DW'(row);
            rec_y     <= DW'(col);
            rec_flags <= '0;
            if (doutGrid >= POS_LIMIT) begin
              rec_flags[FLAG_RANGE] <= 1'b1;
              rec_valid             <= 1'b1;
              state                 <= S_EMIT;
            end else begin
              state <= S_POS_RD;
            end
          end
        end
        S_POS_RD: begin
          rePX    <= 1'b1;
          rePY    <= 1'b1;
          addrPos <= rec_node[POS_AW-1:0];
          state   <= S_POS_WAIT;
        end
        S_POS_WAIT: state <= S_POS_CHK;
        S_POS_CHK: begin
          rec_flags[FLAG_MISMATCH] <= (doutPX != rec_x) || (doutPY != rec_y);
          rec_valid                <= 1'b1;
          state                    <= S_EMIT;
        end
        S_EMIT: begin
          if (rec_ready) begin
            rec_valid  <= 1'b0;
            cell_count <= sat_inc(cell_count);
            if (rec_flags != 2'b00) err_count <= sat_inc(err_count);
            state <= S_ADV;
          end
        end
        S_ADV: state <= last ? S_DONE : S_GRD_RD;
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_dump.sv
// Directed bench for placement_dump: synchronous RAM models, table-driven scans,
// plus a back-pressure stall sequence and a mid-scan reset sequence.
module tb_placement_dump;
  import placement_pkg::*;

  logic               clk = 1'b0;
  logic               reset, start, rec_ready;
  logic               busy, done, reGrid, rePX, rePY, rec_valid;
  logic [GRID_AW-1:0] addrGrid;
  logic [POS_AW-1:0]  addrPos;
  logic [DW-1:0]      doutGrid = '0, doutPX = '0, doutPY = '0;
  logic [DW-1:0]      rec_node, rec_x, rec_y;
  logic [1:0]         rec_flags;
  logic [15:0]        cell_count, err_count;

  always #5 clk = ~clk;

  placement_dump dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
    .rePX(rePX), .rePY(rePY), .addrPos(addrPos), .doutPX(doutPX), .doutPY(doutPY),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_node(rec_node),
    .rec_x(rec_x), .rec_y(rec_y), .rec_flags(rec_flags),
    .cell_count(cell_count), .err_count(err_count)
  );

  logic [DW-1:0] grid_mem [0:N*N-1];
  logic [DW-1:0] px_mem   [0:127];
  logic [DW-1:0] py_mem   [0:127];

  always @(posedge clk) begin
    if (reGrid) doutGrid <= grid_mem[addrGrid[5:0]];
    if (rePX)   doutPX   <= px_mem[addrPos];
    if (rePY)   doutPY   <= py_mem[addrPos];
  end

  typedef struct {
    logic [DW-1:0] node, x, y;
    logic [1:0]    flags;
  } rec_t;

  rec_t               recq[$];
  int                 posrd, done_cnt;
  logic               grd_first;
  logic [GRID_AW-1:0] first_addr;
  logic               mon_clr;

  always @(posedge clk) begin
    if (mon_clr) begin
      recq.delete();
      posrd      <= 0;
      done_cnt   <= 0;
      grd_first  <= 1'b1;
      first_addr <= '0;
    end else begin
      if (rec_valid && rec_ready) recq.push_back('{rec_node, rec_x, rec_y, rec_flags});
      if (rePX) posrd <= posrd + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (reGrid && grd_first) begin
        first_addr <= addrGrid;
        grd_first  <= 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N*N; i++) grid_mem[i] = EMPTY;
    for (int i = 0; i < 128; i++) begin
      px_mem[i] = EMPTY;
      py_mem[i] = EMPTY;
    end
  endtask

  task automatic load(input int a, input int n, input int px, input int py);
    if (a >= 0) begin
      grid_mem[a] = 32'(n);
      if (n < 128) begin
        px_mem[n] = 32'(px);
        py_mem[n] = 32'(py);
      end
    end
  endtask

  task automatic mon_reset();
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_seen"}, done, 1);
  endtask

  typedef struct {
    int a0, n0, px0, py0, a1, n1, px1, py1;
    int recs;
    int en0, ex0, ey0, ef0, en1, ex1, ey1, ef1;
    int cc, ec, prd;
  } vec_t;

  vec_t vecs[6];
  int   cyc;
  rec_t snap;

  initial begin
    vecs[0] = '{-1,   0,  0,  0, -1,   0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{21,   3,  2,  5, -1,   0, 0, 0, 1,   3, 2, 5, 0,   0, 0, 0, 0, 1, 0, 1};
    vecs[2] = '{21,   3,  2,  4, -1,   0, 0, 0, 1,   3, 2, 5, 1,   0, 0, 0, 0, 1, 1, 1};
    vecs[3] = '{63, 200,  0,  0, -1,   0, 0, 0, 1, 200, 7, 7, 2,   0, 0, 0, 0, 1, 1, 0};
    vecs[4] = '{10,   5, -1, -1, 40, 127, 5, 0, 2,   5, 1, 2, 1, 127, 5, 0, 0, 2, 1, 2};
    vecs[5] = '{ 0, 128,  0,  0,  1,   0, 0, 1, 2, 128, 0, 0, 2,   0, 0, 1, 0, 2, 1, 1};

    reset = 1'b0; start = 1'b0; rec_ready = 1'b1; mon_clr = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, reGrid, rePX, rePY, rec_valid, rec_flags, cell_count, err_count}, 0);
    reset = 1'b1;
    mon_clr = 1'b0;

    for (int i = 0; i < 6; i++) begin
      clear_mem();
      load(vecs[i].a0, vecs[i].n0, vecs[i].px0, vecs[i].py0);
      load(vecs[i].a1, vecs[i].n1, vecs[i].px1, vecs[i].py1);
      mon_reset();
      pulse_start();
      wait_done($sformatf("v%0d", i), cyc);
      @(negedge clk);
      if (i == 0) chk("empty_scan_cycles", (cyc >= 256 && cyc <= 270), 1);
      chk($sformatf("v%0d_rec_count", i), recq.size(), vecs[i].recs);
      if (recq.size() > 0) begin
        chk($sformatf("v%0d_rec0", i), {recq[0].node, recq[0].x[7:0], recq[0].y[7:0], 6'd0, recq[0].flags},
            {32'(vecs[i].en0), 8'(vecs[i].ex0), 8'(vecs[i].ey0), 6'd0, 2'(vecs[i].ef0)});
      end
      if (recq.size() > 1) begin
        chk($sformatf("v%0d_rec1", i), {recq[1].node, recq[1].x[7:0], recq[1].y[7:0], 6'd0, recq[1].flags},
            {32'(vecs[i].en1), 8'(vecs[i].ex1), 8'(vecs[i].ey1), 6'd0, 2'(vecs[i].ef1)});
      end
      chk($sformatf("v%0d_counts", i), {cell_count, err_count}, {16'(vecs[i].cc), 16'(vecs[i].ec)});
      chk($sformatf("v%0d_pos_reads", i), posrd, vecs[i].prd);
      chk($sformatf("v%0d_busy_after", i), busy, 0);
    end

    // Back-pressure: first record held for 10 cycles with rec_ready low.
    clear_mem();
    load(9, 4, 1, 1);
    load(50, 6, 6, 2);
    mon_reset();
    rec_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!rec_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_valid_seen", rec_valid, 1);
    snap = '{rec_node, rec_x, rec_y, rec_flags};
    chk("stall_first_rec", {snap.node, snap.x, snap.y, snap.flags}, {32'd4, 32'd1, 32'd1, 2'd0});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k), {rec_valid, rec_node, rec_x, rec_y, rec_flags},
          {1'b1, snap.node, snap.x, snap.y, snap.flags});
    end
    rec_ready = 1'b1;
    wait_done("stall", cyc);
    @(negedge clk);
    chk("stall_rec_count", recq.size(), 2);
    if (recq.size() == 2) begin
      chk("stall_order", {recq[0].node, recq[1].node}, {32'd4, 32'd6});
      chk("stall_rec1_xy", {recq[1].x, recq[1].y, recq[1].flags}, {32'd6, 32'd2, 2'd0});
    end
    chk("stall_counts", {cell_count, err_count}, {16'd2, 16'd0});

    // Reset during POS_WAIT aborts the scan without a done pulse.
    clear_mem();
    load(21, 3, 2, 5);
    mon_reset();
    pulse_start();
    cyc = 0;
    while (!rePX && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_pos_wait_reached", rePX, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_state", {busy, rec_valid, done}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_record", recq.size(), 0);
    mon_reset();
    pulse_start();
    wait_done("rescan", cyc);
    @(negedge clk);
    chk("rescan_first_addr", first_addr, 0);
    chk("rescan_rec_count", recq.size(), 1);
    if (recq.size() == 1)
      chk("rescan_rec", {recq[0].node, recq[0].x, recq[0].y, recq[0].flags}, {32'd3, 32'd2, 32'd5, 2'd0});
    chk("rescan_counts", {cell_count, err_count}, {16'd1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
